seg_scan: RTL and testbench



---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_scan_timer.sv | 80 ++++++++
 rtl/seg_scan.sv | 79 +++++++
 tb/tb_seg_scan.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed segment-display scanner.
package seg_pkg;

   localparam logic [7:0] SEG_OFF    = 8'hFF;
   localparam int         NUM_DIGITS = 8;

   typedef enum logic [1:0] {
      START = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } seg_state_t;

   // Active-low one-cold digit select for a digit index.
   function automatic logic [7:0] an_sel(input logic [2:0] idx);
      return ~(8'h01 << idx);
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Phase counter and slot sequencer for seg_scan; exposes the next-cycle
// phase/digit so the top level can register its outputs on the same edge.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   START | one cycle after reset, everything off; next edge starts frame
//   BLANK | all-off gap ahead of a digit, BLANK_CYCLES clocks
//   ON    | digit idx driven, DIGIT_CYCLES clocks; then idx advances
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 1000,
   parameter int BLANK_CYCLES = 50
) (
   input  logic       clk,
   input  logic       rst,
   output seg_state_t phase_next,
   output logic [2:0] idx_next,
   output logic       frame_start
);

   localparam int CNT_BIG = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_MAX = (CNT_BIG < 2) ? 2 : CNT_BIG;
   localparam int CW      = $clog2(CNT_MAX);
   localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = HAS_BLANK ? CW'(BLANK_CYCLES - 1) : '0;

   seg_state_t    phase;
   logic [2:0]    idx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= START;
         idx   <= 3'd0;
         cnt   <= '0;
      end else begin
         phase <= phase_next;
         idx   <= idx_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      phase_next  = phase;
      idx_next    = idx;
      cnt_next    = cnt + 1'b1;
      frame_start = 1'b0;
      case (phase)
         START: begin
            cnt_next    = '0;
            idx_next    = 3'd0;
            frame_start = 1'b1;
            phase_next  = HAS_BLANK ? BLANK : ON;
         end
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               cnt_next   = '0;
               phase_next = ON;
            end
         end
         ON: begin
            if (cnt == DIGIT_LAST) begin
               cnt_next    = '0;
               idx_next    = idx + 1'b1;
               frame_start = (idx == 3'd7);
               phase_next  = HAS_BLANK ? BLANK : ON;
            end
         end
         default: begin
            cnt_next   = '0;
            phase_next = START;
         end
      endcase
   end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit display multiplexer: snapshots patterns once per frame and
// drives one digit at a time on a shared active-low segment bus.
module seg_scan
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 1000,
   parameter int BLANK_CYCLES = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_seg1,
   input  logic [7:0] i_seg2,
   input  logic [7:0] i_seg3,
   input  logic [7:0] i_seg4,
   input  logic [7:0] i_seg5,
   input  logic [7:0] i_seg6,
   input  logic [7:0] i_seg7,
   input  logic [7:0] i_seg8,
   input  logic [7:0] i_en,
   output logic [7:0] o_seg,
   output logic [7:0] o_an,
   output logic       o_frame
);

   seg_state_t phase_next;
   logic [2:0] idx_next;
   logic       frame_start;

   logic [7:0] seg_in    [NUM_DIGITS];
   logic [7:0] snap      [NUM_DIGITS];
   logic [7:0] snap_next [NUM_DIGITS];

   seg_scan_timer #(
      .DIGIT_CYCLES(DIGIT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .phase_next (phase_next),
      .idx_next   (idx_next),
      .frame_start(frame_start)
   );

   assign seg_in[0] = i_seg1;
   assign seg_in[1] = i_seg2;
   assign seg_in[2] = i_seg3;
   assign seg_in[3] = i_seg4;
   assign seg_in[4] = i_seg5;
   assign seg_in[5] = i_seg6;
   assign seg_in[6] = i_seg7;
   assign seg_in[7] = i_seg8;

   // Fresh inputs are forwarded so slot 0 shows them even with no blank gap.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         snap_next[i] = frame_start ? seg_in[i] : snap[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap    <= '{default: SEG_OFF};
         o_seg   <= SEG_OFF;
         o_an    <= SEG_OFF;
         o_frame <= 1'b0;
      end else begin
         snap    <= snap_next;
         o_frame <= frame_start;
         if (phase_next == ON && i_en[idx_next]) begin
            o_an  <= an_sel(idx_next);
            o_seg <= snap_next[idx_next];
         end else begin
            o_an  <= SEG_OFF;
            o_seg <= SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: one build with a blank gap, one without.
module tb_seg_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] seg_in [8];
   logic [7:0] en;
   logic [7:0] o_seg, o_an, o_seg0, o_an0;
   logic       o_frame, o_frame0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seg_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .i_seg1(seg_in[0]), .i_seg2(seg_in[1]), .i_seg3(seg_in[2]), .i_seg4(seg_in[3]),
      .i_seg5(seg_in[4]), .i_seg6(seg_in[5]), .i_seg7(seg_in[6]), .i_seg8(seg_in[7]),
      .i_en(en), .o_seg(o_seg), .o_an(o_an), .o_frame(o_frame)
   );

   seg_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .i_seg1(seg_in[0]), .i_seg2(seg_in[1]), .i_seg3(seg_in[2]), .i_seg4(seg_in[3]),
      .i_seg5(seg_in[4]), .i_seg6(seg_in[5]), .i_seg7(seg_in[6]), .i_seg8(seg_in[7]),
      .i_en(en), .o_seg(o_seg0), .o_an(o_an0), .o_frame(o_frame0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sel(input int s);
      return ~(8'h01 << s);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
      check("an_onehot",  32'($countones(~o_an)  > 1), 0);
      check("an0_onehot", 32'($countones(~o_an0) > 1), 0);
   endtask

   // One 48-cycle frame of the gapped build; optional mid-frame input change or reset.
   task automatic run_frame(input logic [63:0] pat, input logic [7:0] m, input int chg_c,
                            input logic [7:0] chg_v, input int rst_c, input string nm);
      int slot;
      bit on;
      en = m;
      for (int c = 0; c < 48; c++) begin
         tick();
         slot = c / 6;
         on   = (c % 6 >= 2) && m[slot];
         check($sformatf("%s c%0d an", nm, c),  o_an,  on ? sel(slot) : 8'hFF);
         check($sformatf("%s c%0d seg", nm, c), o_seg, on ? pat[8*slot +: 8] : 8'hFF);
         check($sformatf("%s c%0d frame", nm, c), o_frame, (c == 0));
         if (c == chg_c) seg_in[2] = chg_v;
         if (c == rst_c) begin
            #2 rst = 1'b1;
            #1;
            check("async_rst an",  o_an,  8'hFF);
            check("async_rst seg", o_seg, 8'hFF);
            return;
         end
      end
   endtask

   initial begin
      logic [63:0] pat;
      int k, slot;
      bit on;

      en = 8'hFF;
      for (int i = 0; i < 8; i++) seg_in[i] = 8'hFF;
      seg_in[0] = 8'h03;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("c0 an",    o_an,    8'hFF);
      check("c0 seg",   o_seg,   8'hFF);
      check("c0 frame", o_frame, 0);
      check("c0 an0",   o_an0,   8'hFF);
      check("c0 frame0", o_frame0, 0);

      for (int c = 1; c <= 48; c++) begin
         tick();
         k    = c - 1;
         slot = k / 6;
         on   = (k % 6) >= 2;
         check($sformatf("p1 c%0d an", c),  o_an,  on ? sel(slot) : 8'hFF);
         check($sformatf("p1 c%0d seg", c), o_seg, (on && slot == 0) ? 8'h03 : 8'hFF);
         check($sformatf("p1 c%0d frame", c), o_frame, (k == 0));
         if (c <= 33) begin
            k    = (c - 1) % 32;
            slot = k / 4;
            check($sformatf("nb c%0d an", c),  o_an0,  sel(slot));
            check($sformatf("nb c%0d seg", c), o_seg0, (slot == 0) ? 8'h03 : 8'hFF);
            check($sformatf("nb c%0d frame", c), o_frame0, (k == 0));
         end
      end

      for (int i = 0; i < 8; i++) seg_in[i] = 8'h10 + 8'(i);
      pat = 64'h1716_1514_1312_1110;
      run_frame(pat, 8'hFF, -1, 8'h00, -1, "f1");

      seg_in[2] = 8'h22;
      pat[23:16] = 8'h22;
      run_frame(pat, 8'hFF, 7, 8'h55, -1, "f2");

      pat[23:16] = 8'h55;
      run_frame(pat, 8'hFF, -1, 8'h00, -1, "f3");
      run_frame(pat, 8'b1111_1011, -1, 8'h00, -1, "f4");
      run_frame(pat, 8'hFF, -1, 8'h00, 33, "f5");

      @(posedge clk);
      #1;
      check("in_rst an",    o_an,    8'hFF);
      check("in_rst frame", o_frame, 0);
      rst = 1'b0;
      check("r c0 an",  o_an,  8'hFF);
      check("r c0 seg", o_seg, 8'hFF);
      tick(); check("r c1 an", o_an, 8'hFF); check("r c1 frame", o_frame, 1);
      tick(); check("r c2 an", o_an, 8'hFF); check("r c2 frame", o_frame, 0);
      for (int c = 3; c <= 6; c++) begin
         tick();
         check($sformatf("r c%0d an", c),  o_an,  8'hFE);
         check($sformatf("r c%0d seg", c), o_seg, 8'h10);
      end
      tick(); check("r c7 an", o_an, 8'hFF);
      tick(); check("r c8 an", o_an, 8'hFF);
      tick(); check("r c9 an", o_an, 8'hFD); check("r c9 seg", o_seg, 8'h11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
